// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : MEM-stage load/store request/response bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Fixed-latency word data memory answering MEM-stage requests.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  data_mem_responder_if.slave bus
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_we;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [31:0]          r_mem [DEPTH];

  logic                 w_ready;
  logic                 w_stall;
  logic                 w_accept;
  logic                 w_access;
  logic                 w_err;
  logic [c_ADDR_W-1:0]  w_idx;

  // Decode works only on the captured request, so req_* may change freely in flight.
  assign w_idx = r_addr[c_ADDR_W+1:2];
  assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[31:c_ADDR_W+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_stall      = 1'b0;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_stall = bus.req_valid;
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == '0) begin
          w_access     = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_CNT_W'(LATENCY - 1);
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      if (w_access) begin
        r_rdata <= (r_we || w_err) ? 32'h0 : r_mem[w_idx];
        r_err   <= w_err;
      end
    end
  end

  // Array is not reset; a reset before the access edge keeps the FSM out of WAIT.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.stall      = w_stall;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule
`default_nettype wire
